// File: rtl/ilog_if.sv
// ----------------------------------------------------------------------------
// ilog_if
//   Start/ready request bus for the integer-logarithm unit. It uses the same
//   handshake as the power unit, so one controller can drive both.
//
//   Signals
//     start  master->slave  request, taken only while ready=1
//     inx    master->slave  base x (W bits), sampled with start
//     iny    master->slave  argument y (W bits), sampled with start
//     ready  slave->master  1 = idle and accepting start
//     done   slave->master  one-cycle pulse when out/err are updated
//     err    slave->master  1 = last request invalid (x<2 or y==0)
//     out    slave->master  result k (KW bits), held until next completion
// ----------------------------------------------------------------------------
interface ilog_if #(
   parameter int W  = 16,
   parameter int KW = 8
);
   logic          start;
   logic [W-1:0]  inx;
   logic [W-1:0]  iny;
   logic          ready;
   logic          done;
   logic          err;
   logic [KW-1:0] out;

   modport master (
      output start, inx, iny,
      input  ready, done, err, out
   );

   modport slave (
      input  start, inx, iny,
      output ready, done, err, out
   );
endinterface

// File: rtl/ilog_unit.sv
// ----------------------------------------------------------------------------
// ilog_unit
//   Sequential integer logarithm: out = floor(log_x(y)). This is the largest
//   k with x^k <= y. The unit finds it by multiplying a running power p by x
//   until the product passes y. It takes exactly out+1 busy cycles.
//
//   Ports
//     clk   rising-edge clock
//     nrst  asynchronous active-low reset; it discards any in-flight request
//     bus   ilog_if slave port (start/inx/iny in; ready/done/err/out out)
// ----------------------------------------------------------------------------
module ilog_unit #(
   parameter int W  = 16,
   parameter int KW = 8
) (
   input  logic   clk,
   input  logic   nrst,
   ilog_if.slave  bus
);

   typedef enum logic {S_READY = 1'b0, S_BUSY = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    x_q, x_d;
   logic [W-1:0]    y_q, y_d;
   logic [W-1:0]    p_q, p_d;
   logic [KW-1:0]   k_q, k_d;
   logic [KW-1:0]   out_q, out_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   // The product is kept at full 2W width. An overflow past W bits must read
   // as "greater than y" and must never wrap back below it.
   logic [2*W-1:0]  prod;

   assign prod = {{W{1'b0}}, p_q} * {{W{1'b0}}, x_q};

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      p_d     = p_q;
      k_d     = k_q;
      out_d   = out_q;
      err_d   = err_q;
      done_d  = 1'b0;
      case (state_q)
         S_READY: begin
            if (bus.start) begin
               // x<2 never terminates (x=1) or is undefined (x=0); y=0 has no log
               if (bus.inx < W'(2) || bus.iny == '0) begin
                  out_d  = '0;
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  x_d     = bus.inx;
                  y_d     = bus.iny;
                  p_d     = W'(1);
                  k_d     = '0;
                  err_d   = 1'b0;
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            if (prod > {{W{1'b0}}, y_q}) begin
               out_d   = k_q;
               done_d  = 1'b1;
               state_d = S_READY;
            end else begin
               // prod <= y < 2^W here, so the truncation drops only zero bits
               p_d = prod[W-1:0];
               k_d = k_q + KW'(1);
            end
         end
         default: state_d = S_READY;
      endcase
   end

   // Operand registers hold data only and need no reset value.
   always_ff @(posedge clk) begin
      x_q <= x_d;
      y_q <= y_d;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_READY;
         p_q     <= '0;
         k_q     <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         k_q     <= k_d;
         out_q   <= out_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.ready = (state_q == S_READY);
   assign bus.done  = done_q;
   assign bus.err   = err_q;
   assign bus.out   = out_q;

endmodule

// File: tb/tb_ilog_unit.sv
// ----------------------------------------------------------------------------
// tb_ilog_unit
//   Directed bench for ilog_unit. Each expected value is worked out by hand.
//   Every check goes through chk().
// ----------------------------------------------------------------------------
module tb_ilog_unit;
   localparam int W  = 16;
   localparam int KW = 8;

   logic clk;
   logic nrst;
   int   n_cmp;
   int   n_bad;

   ilog_if #(.W(W), .KW(KW)) u_if ();

   ilog_unit #(.W(W), .KW(KW)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // Launch one request and wait for done. Then check the result, the error
   // flag, the number of busy cycles and the total latency. The last check
   // confirms that done falls again after one cycle. When inject=1, the task
   // asserts start with other operands partway through the busy phase.
   task automatic run_op(input string tag, input int x, input int y,
                         input int exp_out, input int exp_err, input int exp_busy,
                         input bit inject);
      int busy;
      int lat;
      @(negedge clk);
      u_if.start = 1'b1;
      u_if.inx   = W'(x);
      u_if.iny   = W'(y);
      @(negedge clk);
      u_if.start = 1'b0;
      busy = 0;
      lat  = 0;
      while (u_if.done !== 1'b1 && lat < 200) begin
         if (u_if.ready === 1'b0) busy++;
         lat++;
         if (inject) begin
            u_if.start = (busy == 2);
            u_if.inx   = W'(2);
            u_if.iny   = W'(1000);
         end
         @(negedge clk);
      end
      u_if.start = 1'b0;
      chk({tag, ".done"},  32'(u_if.done), 32'd1);
      chk({tag, ".out"},   32'(u_if.out),  32'(exp_out));
      chk({tag, ".err"},   32'(u_if.err),  32'(exp_err));
      chk({tag, ".ready"}, 32'(u_if.ready), 32'd1);
      chk({tag, ".busy"},  32'(busy),      32'(exp_busy));
      chk({tag, ".lat"},   32'(lat),       32'(exp_busy));
      @(negedge clk);
      chk({tag, ".pulse"}, 32'(u_if.done), 32'd0);
      chk({tag, ".hold"},  32'(u_if.out),  32'(exp_out));
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      nrst = 1'b0;
      u_if.start = 1'b0;
      u_if.inx   = '0;
      u_if.iny   = '0;
      repeat (2) @(negedge clk);
      chk("rst.ready", 32'(u_if.ready), 32'd1);
      chk("rst.done",  32'(u_if.done),  32'd0);
      chk("rst.err",   32'(u_if.err),   32'd0);
      chk("rst.out",   32'(u_if.out),   32'd0);
      nrst = 1'b1;
      @(negedge clk);

      run_op("x3y100",   3,     100,   4,  0, 5,  1'b0);
      run_op("x2ymax",   2,     65535, 15, 0, 16, 1'b0);
      run_op("xmaxymax", 65535, 65535, 1,  0, 2,  1'b0);
      run_op("x10y9",    10,    9,     0,  0, 1,  1'b0);
      run_op("x7y49",    7,     49,    2,  0, 3,  1'b0);
      run_op("e_x1",     1,     50,    0,  1, 0,  1'b0);
      run_op("e_x0",     0,     5,     0,  1, 0,  1'b0);
      run_op("e_y0",     5,     0,     0,  1, 0,  1'b0);
      run_op("x5y124",   5,     124,   2,  0, 3,  1'b0);
      run_op("ign",      3,     100,   4,  0, 5,  1'b1);

      // Assert reset during the busy phase. It takes effect at once, with no clock edge.
      @(negedge clk);
      u_if.start = 1'b1;
      u_if.inx   = W'(2);
      u_if.iny   = W'(1000);
      @(negedge clk);
      u_if.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid.busy", 32'(u_if.ready), 32'd0);
      #2 nrst = 1'b0;
      #1;
      chk("mid.ready", 32'(u_if.ready), 32'd1);
      chk("mid.out",   32'(u_if.out),   32'd0);
      chk("mid.done",  32'(u_if.done),  32'd0);
      @(negedge clk);
      nrst = 1'b1;
      run_op("post", 2, 1000, 9, 0, 10, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
